// File: rtl/pre_if_stage_if.sv
// pre_if_stage_if
//   Connects the pre-IF stage to the rest of the pipeline.
//   master : the pre-IF stage. It receives the fetch back-pressure and the
//            redirect sources. It drives the PC, the instruction SRAM
//            request and the cancel to the fetch stage.
//   slave  : the surrounding pipeline or a testbench.
//   Signals:
//     fs_allow_in      fetch stage can accept a new PC this cycle
//     br_taken/target  resolved taken branch or jump and its target
//     excp_flush       exception commit; redirect to ex_entry
//     ertn_flush       exception return; redirect to era
//     to_fs_valid      pre-IF holds a valid PC for fetch
//     pc, excp_adef    registered PC and its misaligned-fetch flag
//     nextpc           combinational next fetch PC
//     inst_sram_en     instruction SRAM read enable
//     inst_sram_addr   instruction SRAM read address
//     br_taken_cancel  any redirect this cycle
interface pre_if_stage_if;
  logic        fs_allow_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        excp_flush;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] era;
  logic        to_fs_valid;
  logic [31:0] pc;
  logic        excp_adef;
  logic [31:0] nextpc;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic        br_taken_cancel;

  modport master (
    input  fs_allow_in, br_taken, br_target, excp_flush, ex_entry,
           ertn_flush, era,
    output to_fs_valid, pc, excp_adef, nextpc, inst_sram_en,
           inst_sram_addr, br_taken_cancel
  );

  modport slave (
    output fs_allow_in, br_taken, br_target, excp_flush, ex_entry,
           ertn_flush, era,
    input  to_fs_valid, pc, excp_adef, nextpc, inst_sram_en,
           inst_sram_addr, br_taken_cancel
  );
endinterface

// File: rtl/pre_if_stage.sv
// pre_if_stage
//   Pre-fetch stage. Each cycle it selects the next fetch PC from these
//   sources, in priority order: exception entry, exception return, taken
//   branch, buffered redirect, sequential PC. It then issues the
//   instruction SRAM read for that PC.
//   While the fetch stage stalls, a redirect is buffered. The buffered
//   target is then used on the first cycle the fetch stage accepts again.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    pre_if_stage_if.master (redirect inputs, PC/SRAM outputs)
module pre_if_stage (
  input  logic                  clk,
  input  logic                  reset,
  pre_if_stage_if.master        bus
);

  // The PC register sits one word before the boot vector. The first
  // sequential increment after reset therefore fetches 0x1C000000.
  localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic        excp_adef_q, excp_adef_d;
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] pending_target_q, pending_target_d;

  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        redirect;

  // Next-PC selection
  always_comb begin
    seq_pc   = pc_q + 32'd4;
    redirect = bus.excp_flush | bus.ertn_flush | bus.br_taken;
    if (bus.excp_flush)       nextpc = bus.ex_entry;
    else if (bus.ertn_flush)  nextpc = bus.era;
    else if (bus.br_taken)    nextpc = bus.br_target;
    else if (pending_valid_q) nextpc = pending_target_q;
    else                      nextpc = seq_pc;
  end

  // State update
  always_comb begin
    pc_d             = pc_q;
    excp_adef_d      = excp_adef_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    if (reset) begin
      pc_d             = RESET_PC;
      excp_adef_d      = 1'b0;
      pending_valid_d  = 1'b0;
      pending_target_d = 32'h0;
    end else if (bus.fs_allow_in) begin
      // A redirect in this cycle goes straight to pc, so nothing is
      // buffered. Any older buffered target is consumed through nextpc
      // in this same cycle.
      pc_d            = nextpc;
      excp_adef_d     = (nextpc[1:0] != 2'b00);
      pending_valid_d = 1'b0;
    end else if (redirect) begin
      // nextpc already holds the highest-priority target. A newer
      // redirect therefore replaces any older buffered one.
      pending_valid_d  = 1'b1;
      pending_target_d = nextpc;
    end
  end

  always_ff @(posedge clk) begin
    pc_q             <= pc_d;
    excp_adef_q      <= excp_adef_d;
    pending_valid_q  <= pending_valid_d;
    pending_target_q <= pending_target_d;
  end

  // Outputs
  always_comb begin
    bus.to_fs_valid     = ~reset;
    bus.pc              = pc_q;
    bus.excp_adef       = excp_adef_q;
    bus.nextpc          = nextpc;
    bus.inst_sram_addr  = nextpc;
    bus.inst_sram_en    = bus.fs_allow_in & ~reset & (nextpc[1:0] == 2'b00);
    bus.br_taken_cancel = redirect;
  end

endmodule

// File: doc/pre_if_stage.md
PRE_IF_STAGE -- requirements
Module: pre_if_stage

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- fs_allow_in  in  1  fetch stage can accept a new PC this cycle.
- br_taken  in  1  branch/jump resolved taken.
- br_target  in  32  branch target.
- excp_flush  in  1  exception commit; redirect to ex_entry.
- ex_entry  in  32  exception entry address.
- ertn_flush  in  1  exception return; redirect to era.
- era  in  32  exception return address.
- to_fs_valid  out  1  pre-IF holds a valid PC for fetch.
- pc  out  32  registered PC presented to the fetch stage.
- excp_adef  out  1  registered misaligned-fetch flag for pc.
- nextpc  out  32  PC selected for the next fetch (combinational).
- inst_sram_en  out  1  instruction SRAM read enable.
- inst_sram_addr  out  32  instruction SRAM address (= nextpc).
- br_taken_cancel  out  1  any redirect this cycle; fetch stage drops its in-flight slot.

Function
REQ-002 seq_pc SHALL be pc + 32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-003 nextpc SHALL use this fixed priority: excp_flush -> ex_entry; else ertn_flush -> era; else br_taken -> br_target; else pending_valid -> pending_target; else seq_pc.
REQ-004 redirect SHALL be excp_flush | ertn_flush | br_taken.
REQ-005 br_taken_cancel SHALL equal redirect, combinationally, in the same cycle.
REQ-006 When fs_allow_in=1, the pc register SHALL load nextpc and excp_adef SHALL load (nextpc[1:0] != 2'b00).
- When fs_allow_in=0, both SHALL hold.
REQ-007 inst_sram_addr SHALL equal nextpc.
REQ-008 inst_sram_en SHALL be fs_allow_in & ~reset & (nextpc[1:0]==2'b00); no SRAM read is issued for a misaligned PC.
REQ-009 Pending-redirect buffer (pending_valid, pending_target[31:0]):
- Redirect with fs_allow_in=0: set pending_valid=1 and pending_target = the target chosen by REQ-003.
- A newer redirect overwrites an older pending one.
- When fs_allow_in=1: clear pending_valid; the pending target is consumed via nextpc in that cycle.
- Redirect and fs_allow_in=1 in the same cycle: the new target goes straight to pc and pending is cleared, not set.
REQ-010 to_fs_valid SHALL be 1 in every cycle after reset deasserts; it SHALL be 0 while reset=1.
REQ-011 Simultaneous excp_flush and br_taken: the exception wins; the branch is discarded and not buffered.
REQ-012 Latency:
- A redirect asserted in cycle N with fs_allow_in=1 appears on pc in cycle N+1.
- A redirect in cycle N with fs_allow_in=0 appears on pc in the cycle after fs_allow_in next becomes 1.

Reset
REQ-013 While reset=1, the block SHALL force pc=32'h1BFFFFFC, excp_adef=0, pending_valid=0, pending_target=0, inst_sram_en=0, to_fs_valid=0.
REQ-014 In the first cycle after reset deasserts with fs_allow_in=1: nextpc=32'h1C000000 and inst_sram_en=1.
REQ-015 Reset asserted mid-stall SHALL discard any pending redirect.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset release, fs_allow_in=1 for 4 cycles -> inst_sram_addr 1C000000, 1C000004, 1C000008, 1C00000C; pc lags by one cycle.
- fs_allow_in=0 for 3 cycles at pc=1C000010 -> pc holds 1C000010, inst_sram_en=0, nextpc=1C000014.
- br_taken=1, br_target=1C000100, fs_allow_in=0, then allow after 2 cycles -> br_taken_cancel=1 in the branch cycle; pc=1C000100 the cycle after allow; pending cleared.
- excp_flush=1 (ex_entry=1C008000) with br_taken=1 (br_target=1C000200) -> pc=1C008000; 1C000200 never appears.
- br_target=1C000102 -> inst_sram_en=0 that cycle; next cycle pc=1C000102, excp_adef=1; following nextpc=1C000106.
- Pending redirect set, then reset pulsed -> pc=1BFFFFFC; the first fetch after reset is at 1C000000, not the pending target.
